// File: rtl/ap_pkg.sv
// ap_pkg: shared op encodings, sequencer state type and width helper.
package ap_pkg;
    localparam logic [1:0] AP_OP_CMP_SET   = 2'b00;
    localparam logic [1:0] AP_OP_CMP_OR    = 2'b01;
    localparam logic [1:0] AP_OP_WRITE     = 2'b10;
    localparam logic [1:0] AP_OP_CMP_WRITE = 2'b11;

    typedef enum logic [1:0] {IDLE, CMP, WR} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/ap_pass_sequencer_if.sv
// ap_pass_sequencer_if: host command channel, CAM drive/tag signals and status.
interface ap_pass_sequencer_if
    import ap_pkg::*;
#(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 128
);
    localparam int CW = clog2(CELL_QUANT + 1);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [WORD_SIZE-1:0]  cmd_key;
    logic [WORD_SIZE-1:0]  cmd_cmp_mask;
    logic [WORD_SIZE-1:0]  cmd_wdata;
    logic [WORD_SIZE-1:0]  cmd_wr_mask;
    logic [CELL_QUANT-1:0] cam_tags;
    logic                  cam_mode;
    logic                  cam_wea;
    logic                  cam_direction;
    logic [WORD_SIZE-1:0]  cam_key_v;
    logic [WORD_SIZE-1:0]  cam_key_h;
    logic [WORD_SIZE-1:0]  cam_mask_v;
    logic [WORD_SIZE-1:0]  cam_mask_h;
    logic [WORD_SIZE-1:0]  cam_dina;
    logic [CELL_QUANT-1:0] cam_wea_ctrl_ap;
    logic [CELL_QUANT-1:0] tag_reg_q;
    logic                  match_any;
    logic [CW-1:0]         match_count;
    logic                  done;

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_cmp_mask, cmd_wdata, cmd_wr_mask, cam_tags,
        input  cmd_ready, cam_mode, cam_wea, cam_direction, cam_key_v, cam_key_h,
               cam_mask_v, cam_mask_h, cam_dina, cam_wea_ctrl_ap, tag_reg_q,
               match_any, match_count, done
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_cmp_mask, cmd_wdata, cmd_wr_mask, cam_tags,
        output cmd_ready, cam_mode, cam_wea, cam_direction, cam_key_v, cam_key_h,
               cam_mask_v, cam_mask_h, cam_dina, cam_wea_ctrl_ap, tag_reg_q,
               match_any, match_count, done
    );
endinterface

// File: rtl/ap_popcount.sv
// ap_popcount: combinational population count of an N-bit vector.
module ap_popcount
    import ap_pkg::*;
#(
    parameter int N = 128,
    parameter int W = clog2(N + 1)
) (
    input  logic [N-1:0] v,
    output logic [W-1:0] c
);
    always_comb begin
        c = '0;
        for (int i = 0; i < N; i++) c = c + W'(v[i]);
    end
endmodule

// File: rtl/ap_pass_sequencer.sv
// ap_pass_sequencer: turns host AP commands into CAM compare and tag-guided parallel-write phases.
// Phase outputs are registered from the next state so each phase holds steady for its whole cycle.
module ap_pass_sequencer
    import ap_pkg::*;
#(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 128
) (
    input logic clock,
    input logic rst,
    ap_pass_sequencer_if.slave bus
);
    localparam int CW = clog2(CELL_QUANT + 1);
    state_t state, state_d;
    logic [1:0] op_q;
    logic [WORD_SIZE-1:0] key_q, cmask_q, wdata_q, wmask_q, key, cmask, wdata, wmask;
    logic [CELL_QUANT-1:0] tag_d;
    logic [CW-1:0] count_d;
    logic accept, done_d;

    ap_popcount #(.N(CELL_QUANT), .W(CW)) u_popcount (.v(tag_d), .c(count_d));

    assign bus.cmd_ready     = state == IDLE;
    assign bus.cam_wea       = 1'b0;
    assign bus.cam_direction = 1'b0;
    assign bus.cam_key_h     = bus.cam_key_v;
    assign bus.cam_mask_h    = bus.cam_mask_v;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_d;
    end

    // Fields are taken straight from the bus on the accept edge so the first phase needs no extra cycle.
    always_comb begin
        accept  = bus.cmd_valid && state == IDLE;
        key     = accept ? bus.cmd_key : key_q;
        cmask   = accept ? bus.cmd_cmp_mask : cmask_q;
        wdata   = accept ? bus.cmd_wdata : wdata_q;
        wmask   = accept ? bus.cmd_wr_mask : wmask_q;
        state_d = state == IDLE ? (accept ? (bus.cmd_op == AP_OP_WRITE ? WR : CMP) : IDLE)
                : state == CMP && op_q == AP_OP_CMP_WRITE ? WR : IDLE;
        tag_d   = state != CMP ? bus.tag_reg_q
                : op_q == AP_OP_CMP_OR ? bus.tag_reg_q | bus.cam_tags : bus.cam_tags;
        done_d  = state != IDLE && state_d == IDLE;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            op_q                <= '0;
            key_q               <= '0;
            cmask_q             <= '0;
            wdata_q             <= '0;
            wmask_q             <= '0;
            bus.cam_mode        <= 1'b0;
            bus.cam_key_v       <= '0;
            bus.cam_mask_v      <= '0;
            bus.cam_dina        <= '0;
            bus.cam_wea_ctrl_ap <= '0;
            bus.tag_reg_q       <= '0;
            bus.match_any       <= 1'b0;
            bus.match_count     <= '0;
            bus.done            <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= bus.cmd_op;
                key_q   <= bus.cmd_key;
                cmask_q <= bus.cmd_cmp_mask;
                wdata_q <= bus.cmd_wdata;
                wmask_q <= bus.cmd_wr_mask;
            end
            bus.cam_mode        <= state_d == WR;
            bus.cam_key_v       <= state_d == CMP ? key : '0;
            bus.cam_mask_v      <= state_d == CMP ? cmask : state_d == WR ? wmask : '0;
            bus.cam_dina        <= state_d == WR ? wdata : '0;
            bus.cam_wea_ctrl_ap <= state_d == WR ? tag_d : '0;
            bus.tag_reg_q       <= tag_d;
            bus.match_any       <= |tag_d;
            bus.match_count     <= count_d;
            bus.done            <= done_d;
        end
    end
endmodule

// File: tb/tb_ap_pass_sequencer.sv
// tb_ap_pass_sequencer: CAM environment model plus a per-cycle expected-phase scoreboard.
module tb_ap_pass_sequencer;
    import ap_pkg::*;
    localparam int WS = 8;
    localparam int CQ = 128;

    logic clock = 1'b0;
    logic rst = 1'b1;
    always #5 clock = ~clock;

    ap_pass_sequencer_if #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) bus();
    ap_pass_sequencer #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) dut (.clock(clock), .rst(rst), .bus(bus));

    typedef struct {
        logic          mode;
        logic [WS-1:0] key;
        logic [WS-1:0] mask;
        logic [WS-1:0] dina;
        logic [CQ-1:0] wea;
        logic [CQ-1:0] tag;
        logic          ready;
        logic          done;
        logic          wr;
    } exp_t;

    logic [WS-1:0] mem [CQ];
    logic [WS-1:0] model_mem [CQ];
    exp_t q[$];
    logic [CQ-1:0] m_tag = '0;
    int tests = 0;
    int fails = 0;
    int n_acc = 0;

    task automatic chk(input string n, input logic [CQ-1:0] a, input logic [CQ-1:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic exp_t mk(input logic m, input logic [WS-1:0] k, input logic [WS-1:0] mk_,
                                input logic [WS-1:0] d, input logic [CQ-1:0] w, input logic [CQ-1:0] t,
                                input logic r, input logic dn, input logic wr);
        exp_t e;
        e.mode = m; e.key = k; e.mask = mk_; e.dina = d; e.wea = w; e.tag = t;
        e.ready = r; e.done = dn; e.wr = wr;
        return e;
    endfunction

    // CAM environment: asynchronous match, parallel write at the end of a tag-guided write cycle
    always_comb begin
        bus.cam_tags = '0;
        for (int i = 0; i < CQ; i++)
            bus.cam_tags[i] = ((mem[i] ^ bus.cam_key_v) & bus.cam_mask_v) == '0;
    end

    always @(posedge clock)
        if (bus.cam_mode)
            for (int i = 0; i < CQ; i++)
                if (bus.cam_wea_ctrl_ap[i]) mem[i] = (mem[i] & ~bus.cam_mask_v) | (bus.cam_dina & bus.cam_mask_v);

    // Scoreboard: one expected entry per cycle of each command; idle otherwise
    always @(negedge clock) begin
        exp_t e;
        logic [CQ-1:0] nt;
        logic same;
        if (rst) begin
            q.delete();
            m_tag = '0;
        end else begin
            e = q.size() != 0 ? q.pop_front() : mk(1'b0, '0, '0, '0, '0, m_tag, 1'b1, 1'b0, 1'b0);
            if (e.wr)
                for (int i = 0; i < CQ; i++)
                    if (e.wea[i]) model_mem[i] = (model_mem[i] & ~e.mask) | (e.dina & e.mask);
            chk("cam_mode", bus.cam_mode, e.mode);
            chk("cam_wea", bus.cam_wea, 0);
            chk("cam_direction", bus.cam_direction, 0);
            chk("cam_key_v", bus.cam_key_v, e.key);
            chk("cam_key_h", bus.cam_key_h, e.key);
            chk("cam_mask_v", bus.cam_mask_v, e.mask);
            chk("cam_mask_h", bus.cam_mask_h, e.mask);
            chk("cam_dina", bus.cam_dina, e.dina);
            chk("cam_wea_ctrl_ap", bus.cam_wea_ctrl_ap, e.wea);
            chk("tag_reg_q", bus.tag_reg_q, e.tag);
            chk("match_any", bus.match_any, |e.tag);
            chk("match_count", bus.match_count, $countones(e.tag));
            chk("done", bus.done, e.done);
            chk("cmd_ready", bus.cmd_ready, e.ready);
            if (e.done) begin
                same = 1'b1;
                for (int i = 0; i < CQ; i++) if (mem[i] !== model_mem[i]) same = 1'b0;
                chk("cam_contents", same, 1);
            end
            if (q.size() == 0 && bus.cmd_valid) begin
                n_acc++;
                for (int i = 0; i < CQ; i++)
                    nt[i] = ((model_mem[i] ^ bus.cmd_key) & bus.cmd_cmp_mask) == '0;
                if (bus.cmd_op == AP_OP_WRITE) begin
                    q.push_back(mk(1'b1, '0, bus.cmd_wr_mask, bus.cmd_wdata, m_tag, m_tag, 1'b0, 1'b0, 1'b1));
                end else begin
                    if (bus.cmd_op == AP_OP_CMP_OR) nt = nt | m_tag;
                    q.push_back(mk(1'b0, bus.cmd_key, bus.cmd_cmp_mask, '0, '0, m_tag, 1'b0, 1'b0, 1'b0));
                    if (bus.cmd_op == AP_OP_CMP_WRITE)
                        q.push_back(mk(1'b1, '0, bus.cmd_wr_mask, bus.cmd_wdata, nt, nt, 1'b0, 1'b0, 1'b1));
                    m_tag = nt;
                end
                q.push_back(mk(1'b0, '0, '0, '0, '0, m_tag, 1'b1, 1'b1, 1'b0));
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [WS-1:0] k, input logic [WS-1:0] cm,
                         input logic [WS-1:0] wd, input logic [WS-1:0] wm);
        bus.cmd_op = op; bus.cmd_key = k; bus.cmd_cmp_mask = cm;
        bus.cmd_wdata = wd; bus.cmd_wr_mask = wm;
    endtask

    // Issues one command, returns cycles from accept edge to the done cycle (0 if done never pulses)
    task automatic run_cmd(input logic [1:0] op, input logic [WS-1:0] k, input logic [WS-1:0] cm,
                           input logic [WS-1:0] wd, input logic [WS-1:0] wm, output int lat);
        logic ok;
        drive(op, k, cm, wd, wm);
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clock);
            ok = bus.cmd_ready;
        end
        chk("accept_seen", ok, 1);
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        ok = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10 && !ok; n++) begin
            @(negedge clock);
            ok = bus.done;
            if (ok) lat = n;
        end
        chk("done_seen", ok, 1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a0;
        logic ok;
        for (int i = 0; i < CQ; i++) mem[i] = 8'h40 + 8'(i);
        mem[3] = 8'h0F; mem[7] = 8'h0F; mem[10] = 8'h33;
        for (int i = 0; i < CQ; i++) model_mem[i] = mem[i];
        bus.cmd_valid = 1'b0;
        drive(2'b00, '0, '0, '0, '0);
        #2;
        chk("reset_tag", bus.tag_reg_q, 0);
        chk("reset_count", bus.match_count, 0);
        chk("reset_any", bus.match_any, 0);
        chk("reset_ready", bus.cmd_ready, 1);
        chk("reset_done", bus.done, 0);
        chk("reset_mode", bus.cam_mode, 0);
        @(posedge clock);
        #1 rst = 1'b0;
        @(posedge clock);
        #1;

        run_cmd(AP_OP_CMP_SET, 8'h0F, 8'hFF, 8'hAA, 8'hFF, lat);
        chk("cmp_set_latency", lat, 2);
        chk("cmp_set_tag", bus.tag_reg_q, 128'h88);
        chk("cmp_set_count", bus.match_count, 2);
        chk("cmp_set_any", bus.match_any, 1);

        run_cmd(AP_OP_CMP_OR, 8'h33, 8'hFF, 8'h00, 8'h00, lat);
        chk("cmp_or_latency", lat, 2);
        chk("cmp_or_tag", bus.tag_reg_q, 128'h488);
        chk("cmp_or_count", bus.match_count, 3);

        run_cmd(AP_OP_CMP_WRITE, 8'h01, 8'h01, 8'h80, 8'h80, lat);
        chk("cmp_write_latency", lat, 3);
        chk("cmp_write_cell1", mem[1], 8'hC1);
        chk("cmp_write_cell2", mem[2], 8'h42);
        chk("cmp_write_cell3", mem[3], 8'h8F);
        chk("cmp_write_cell10", mem[10], 8'hB3);
        chk("cmp_write_count", bus.match_count, 65);

        // Reset during the write phase of a CMP_WRITE: cell 2 would otherwise become 0x43
        drive(AP_OP_CMP_WRITE, 8'h02, 8'h02, 8'h01, 8'h01);
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_wr_mode", bus.cam_mode, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_mode", bus.cam_mode, 0);
        chk("rst_async_wea_ctrl", bus.cam_wea_ctrl_ap, 0);
        chk("rst_async_tag", bus.tag_reg_q, 0);
        chk("rst_async_count", bus.match_count, 0);
        chk("rst_async_any", bus.match_any, 0);
        chk("rst_async_ready", bus.cmd_ready, 1);
        chk("rst_async_done", bus.done, 0);
        @(posedge clock);
        #1;
        chk("rst_hold_done", bus.done, 0);
        rst = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            ok = ok | bus.done;
        end
        chk("rst_no_done", ok, 0);
        chk("rst_no_write", mem[2], 8'h42);
        @(posedge clock);
        #1;

        run_cmd(AP_OP_WRITE, 8'h00, 8'h00, 8'hFF, 8'hFF, lat);
        chk("empty_write_latency", lat, 2);
        chk("empty_write_cell2", mem[2], 8'h42);
        chk("empty_write_cell3", mem[3], 8'h8F);

        for (int i = 0; i < CQ; i++) begin
            mem[i] = 8'h55;
            model_mem[i] = 8'h55;
        end
        drive(AP_OP_CMP_SET, 8'h55, 8'hFF, 8'h00, 8'h00);
        a0 = n_acc;
        bus.cmd_valid = 1'b1;
        repeat (5) @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge clock);
            ok = bus.done;
        end
        chk("b2b_done_seen", ok, 1);
        @(posedge clock);
        #1;
        chk("b2b_accepts", n_acc - a0, 3);
        chk("b2b_tag", bus.tag_reg_q, {CQ{1'b1}});
        chk("b2b_count", bus.match_count, CQ);

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
